// File: rtl/multitrack_mix_sequencer.sv
// N-track mixer: buffered host instructions set per-track volume/mute between frames,
// then each frame gathers one sample per track, MACs sequentially, saturates and hands off to the DAC.
module multitrack_mix_sequencer #(
  parameter int NUM_TRACKS = 4,
  parameter int SAMPLE_W   = 16,
  parameter int VOL_W      = 8,
  parameter int PROG_DEPTH = 16,
  parameter int ACC_W      = SAMPLE_W + VOL_W + $clog2(NUM_TRACKS) + 1
) (
  input  logic                           axis_aclk,
  input  logic                           axis_aresetn,
  input  logic                           prog_valid,
  input  logic [15:0]                    prog_data,
  output logic                           prog_ready,
  output logic                           prog_overflow,
  input  logic                           execute,
  input  logic [NUM_TRACKS-1:0]          trk_valid,
  input  logic [NUM_TRACKS*SAMPLE_W-1:0] trk_data,
  output logic [NUM_TRACKS-1:0]          trk_ready,
  output logic                           dac_valid,
  output logic [SAMPLE_W-1:0]            dac_data,
  input  logic                           dac_ready,
  output logic [15:0]                    stall_cnt
);

  localparam int PTR_W  = $clog2(PROG_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int IDX_W  = (NUM_TRACKS > 1) ? $clog2(NUM_TRACKS) : 1;
  localparam int PROD_W = SAMPLE_W + VOL_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TRACKS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(PROG_DEPTH);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (SAMPLE_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(64'sd1 <<< (SAMPLE_W - 1)));

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GATHER = 3'd1,
    ST_MAC    = 3'd2,
    ST_SAT    = 3'd3,
    ST_OUT    = 3'd4
  } state_t;

  state_t                  state_r, state_s;
  logic [15:0]             fifo_mem_r [PROG_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]        count_r, count_s;
  logic                    prog_ready_r, prog_overflow_r;
  logic                    fifo_wr_s, fifo_rd_s, fifo_empty_s;
  logic [15:0]             head_s;
  logic [7:0]              instr_arg_s;
  logic [1:0]              instr_op_s;
  logic [5:0]              instr_idx_s;
  logic [VOL_W-1:0]        vol_r [NUM_TRACKS];
  logic [NUM_TRACKS-1:0]   mute_r;
  logic [SAMPLE_W-1:0]     sample_r [NUM_TRACKS];
  logic [IDX_W-1:0]        idx_r;
  logic signed [ACC_W-1:0] acc_r, term_s, shifted_s;
  logic signed [PROD_W-1:0] prod_s;
  logic                    accept_s, stall_s, gather_ok_s;
  logic [NUM_TRACKS-1:0]   trk_ready_r, pop_mask_s;
  logic                    dac_valid_r;
  logic [SAMPLE_W-1:0]     dac_data_r, sat_s;
  logic [15:0]             stall_cnt_r;

  assign fifo_wr_s    = prog_valid && prog_ready_r;
  assign fifo_empty_s = (count_r == {CNT_W{1'b0}});
  assign head_s       = fifo_mem_r[rd_ptr_r];
  assign instr_arg_s  = head_s[15:8];
  assign instr_op_s   = head_s[7:6];
  assign instr_idx_s  = head_s[5:0];
  // Muted tracks never block a frame; a valid muted track is popped and thrown away.
  assign gather_ok_s  = &(trk_valid | mute_r);
  assign pop_mask_s   = ~mute_r | (mute_r & trk_valid);

  assign prog_ready    = prog_ready_r;
  assign prog_overflow = prog_overflow_r;
  assign trk_ready     = trk_ready_r;
  assign dac_valid     = dac_valid_r;
  assign dac_data      = dac_data_r;
  assign stall_cnt     = stall_cnt_r;

  // Next-state and per-cycle control strobes
  always_comb begin
    state_s   = state_r;
    fifo_rd_s = 1'b0;
    accept_s  = 1'b0;
    stall_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          fifo_rd_s = 1'b1;
        end else if (execute) begin
          state_s = ST_GATHER;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_GATHER: begin
        if (!execute) begin
          state_s = ST_IDLE;
        end else if (gather_ok_s) begin
          accept_s = 1'b1;
          state_s  = ST_MAC;
        end else begin
          stall_s = 1'b1;
        end
      end
      ST_MAC: begin
        if (idx_r == LAST_IDX) begin
          state_s = ST_SAT;
        end else begin
          state_s = ST_MAC;
        end
      end
      ST_SAT:  state_s = ST_OUT;
      ST_OUT: begin
        if (dac_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_OUT;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // MAC term for the current track and saturation of the finished sum
  always_comb begin
    prod_s    = $signed(sample_r[idx_r]) * $signed({1'b0, vol_r[idx_r]});
    term_s    = '0;
    shifted_s = acc_r >>> VOL_W;
    sat_s     = '0;
    if (mute_r[idx_r]) begin
      term_s = '0;
    end else begin
      term_s = ACC_W'(prod_s);
    end
    if (shifted_s > SAT_MAX) begin
      sat_s = SAT_MAX[SAMPLE_W-1:0];
    end else if (shifted_s < SAT_MIN) begin
      sat_s = SAT_MIN[SAMPLE_W-1:0];
    end else begin
      sat_s = shifted_s[SAMPLE_W-1:0];
    end
  end

  // FIFO occupancy after this cycle's write/pop
  always_comb begin
    count_s = count_r;
    if (fifo_wr_s && !fifo_rd_s) begin
      count_s = count_r + CNT_W'(1);
    end else if (!fifo_wr_s && fifo_rd_s) begin
      count_s = count_r - CNT_W'(1);
    end else begin
      count_s = count_r;
    end
  end

  // Instruction storage array (no reset needed; occupancy is tracked separately)
  always_ff @(posedge axis_aclk) begin
    if (fifo_wr_s) begin
      fifo_mem_r[wr_ptr_r] <= prog_data;
    end
  end

  // FIFO pointers, registered ready and sticky overflow flag
  always_ff @(posedge axis_aclk or posedge axis_aresetn) begin
    if (axis_aresetn) begin
      wr_ptr_r        <= '0;
      rd_ptr_r        <= '0;
      count_r         <= '0;
      prog_ready_r    <= 1'b1;
      prog_overflow_r <= 1'b0;
    end else begin
      if (fifo_wr_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (fifo_rd_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r      <= count_s;
      prog_ready_r <= (count_s != FULL_CNT);
      if (prog_valid && !prog_ready_r) begin
        prog_overflow_r <= 1'b1;
      end
    end
  end

  // Instruction decode: only ever applied from IDLE, so gains are frozen during a frame
  always_ff @(posedge axis_aclk or posedge axis_aresetn) begin
    if (axis_aresetn) begin
      mute_r <= '0;
      for (int i = 0; i < NUM_TRACKS; i++) begin
        vol_r[i] <= '0;
      end
    end else if (fifo_rd_s) begin
      case (instr_op_s)
        2'b00: begin
          for (int i = 0; i < NUM_TRACKS; i++) begin
            if (instr_idx_s == 6'(i)) vol_r[i] <= VOL_W'(instr_arg_s);
          end
        end
        2'b01: begin
          for (int i = 0; i < NUM_TRACKS; i++) begin
            if (instr_idx_s == 6'(i)) mute_r[i] <= instr_arg_s[0];
          end
        end
        2'b10: begin
          for (int i = 0; i < NUM_TRACKS; i++) begin
            vol_r[i] <= VOL_W'(instr_arg_s);
          end
        end
        2'b11: begin
        end
        default: begin
        end
      endcase
    end
  end

  // Frame datapath: state, sample latch, accumulator, DAC handshake, stall counter
  always_ff @(posedge axis_aclk or posedge axis_aresetn) begin
    if (axis_aresetn) begin
      state_r     <= ST_IDLE;
      idx_r       <= '0;
      acc_r       <= '0;
      trk_ready_r <= '0;
      dac_valid_r <= 1'b0;
      dac_data_r  <= '0;
      stall_cnt_r <= '0;
      for (int i = 0; i < NUM_TRACKS; i++) begin
        sample_r[i] <= '0;
      end
    end else begin
      state_r     <= state_s;
      trk_ready_r <= accept_s ? pop_mask_s : {NUM_TRACKS{1'b0}};
      if (accept_s) begin
        acc_r <= '0;
        idx_r <= '0;
        for (int i = 0; i < NUM_TRACKS; i++) begin
          sample_r[i] <= trk_data[i*SAMPLE_W +: SAMPLE_W];
        end
      end else if (state_r == ST_MAC) begin
        acc_r <= acc_r + term_s;
        idx_r <= idx_r + IDX_W'(1);
      end
      if (state_r == ST_SAT) begin
        dac_data_r  <= sat_s;
        dac_valid_r <= 1'b1;
      end else if (state_r == ST_OUT && dac_ready) begin
        dac_valid_r <= 1'b0;
      end
      if (stall_s && stall_cnt_r != 16'hFFFF) begin
        stall_cnt_r <= stall_cnt_r + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_multitrack_mix_sequencer.sv
// Directed bench for multitrack_mix_sequencer (4 tracks): table of mix vectors plus
// hand-written sequences for reset, mute/stall, FIFO fill/overflow and DAC back-pressure.
module tb_multitrack_mix_sequencer;

  localparam int N  = 4;
  localparam int SW = 16;

  logic            axis_aclk    = 1'b0;
  logic            axis_aresetn = 1'b1;
  logic            prog_valid   = 1'b0;
  logic [15:0]     prog_data    = 16'h0000;
  logic            execute      = 1'b0;
  logic [N-1:0]    trk_valid    = '0;
  logic [N*SW-1:0] trk_data     = '0;
  logic            dac_ready    = 1'b0;
  logic            prog_ready, prog_overflow, dac_valid;
  logic [N-1:0]    trk_ready;
  logic [SW-1:0]   dac_data;
  logic [15:0]     stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 axis_aclk = ~axis_aclk;

  multitrack_mix_sequencer #(
    .NUM_TRACKS(N), .SAMPLE_W(SW), .VOL_W(8), .PROG_DEPTH(16)
  ) dut (
    .axis_aclk(axis_aclk), .axis_aresetn(axis_aresetn),
    .prog_valid(prog_valid), .prog_data(prog_data), .prog_ready(prog_ready),
    .prog_overflow(prog_overflow), .execute(execute),
    .trk_valid(trk_valid), .trk_data(trk_data), .trk_ready(trk_ready),
    .dac_valid(dac_valid), .dac_data(dac_data), .dac_ready(dac_ready),
    .stall_cnt(stall_cnt)
  );

  typedef struct packed {
    logic [7:0]  vol;
    logic [3:0]  mute;
    logic [63:0] samples;   // {trk3, trk2, trk1, trk0}
    logic [15:0] exp_data;
    logic [3:0]  exp_rdy;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge.
  task automatic send_instr(input logic [15:0] w);
    prog_valid = 1'b1;
    prog_data  = w;
    @(negedge axis_aclk);
    prog_valid = 1'b0;
  endtask

  task automatic program_mix(input logic [7:0] vol, input logic [3:0] mute);
    send_instr({vol, 2'b10, 6'd0});
    for (int i = 0; i < N; i++) send_instr({7'b0, mute[i], 2'b01, 6'(i)});
    repeat (8) @(negedge axis_aclk);
  endtask

  // Runs one frame with dac_ready high. lat = cycles from trk_ready pulse to dac_valid.
  task automatic run_frame(input logic [63:0] samples, input logic [3:0] valid,
                           output logic [3:0] rdy, output logic [15:0] dout, output int lat);
    trk_data  = samples;
    trk_valid = valid;
    execute   = 1'b1;
    dac_ready = 1'b1;
    rdy  = 4'b0000;
    dout = 16'h0000;
    lat  = 99;
    for (int i = 0; i < 30; i++) begin
      @(negedge axis_aclk);
      if (trk_ready != 4'b0000) begin
        rdy = trk_ready;
        break;
      end
    end
    execute   = 1'b0;
    trk_valid = 4'b0000;
    if (rdy == 4'b0000) return;
    for (int i = 1; i <= 30; i++) begin
      @(negedge axis_aclk);
      if (dac_valid) begin
        lat  = i;
        dout = dac_data;
        break;
      end
    end
    @(negedge axis_aclk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0]  rdy;
    logic [15:0] dout;
    logic [15:0] held;
    logic [15:0] stall_before;
    logic [15:0] words [17];
    int          lat, cnt, first_low;
    bit          stable, popped, got_valid;

    vecs[0] = '{8'h80, 4'b0000, {16'h0064, 16'hFE0C, 16'h07D0, 16'h03E8}, 16'h0514, 4'b1111};
    vecs[1] = '{8'hFF, 4'b0000, {16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF}, 16'h7FFF, 4'b1111};
    vecs[2] = '{8'hFF, 4'b0000, {16'h8000, 16'h8000, 16'h8000, 16'h8000}, 16'h8000, 4'b1111};
    vecs[3] = '{8'h00, 4'b0000, {16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF}, 16'h0000, 4'b1111};
    vecs[4] = '{8'h80, 4'b1111, {16'h03E8, 16'h03E8, 16'h03E8, 16'h03E8}, 16'h0000, 4'b1111};
    vecs[5] = '{8'h40, 4'b0001, {16'h0004, 16'h04B0, 16'hFCE0, 16'h0190}, 16'h0065, 4'b1111};
    vecs[6] = '{8'hFF, 4'b0000, {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, 16'hFFFC, 4'b1111};
    vecs[7] = '{8'h01, 4'b0000, {16'h0100, 16'h0100, 16'h0100, 16'h0100}, 16'h0004, 4'b1111};

    for (int k = 0; k < 14; k++) words[k] = {8'(k), 2'b11, 6'(k)};
    words[14] = {8'h80, 2'b10, 6'd0};
    words[15] = {8'h00, 2'b00, 6'd36};
    words[16] = {8'h00, 2'b10, 6'd0};

    // Reset state
    repeat (3) @(negedge axis_aclk);
    check("rst_dac_valid", 32'(dac_valid), 32'd0);
    check("rst_dac_data", 32'(dac_data), 32'd0);
    check("rst_trk_ready", 32'(trk_ready), 32'd0);
    check("rst_prog_ready", 32'(prog_ready), 32'd1);
    check("rst_prog_overflow", 32'(prog_overflow), 32'd0);
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    axis_aresetn = 1'b0;
    repeat (2) @(negedge axis_aclk);

    // Table-driven mixes
    for (int v = 0; v < 8; v++) begin
      program_mix(vecs[v].vol, vecs[v].mute);
      run_frame(vecs[v].samples, 4'b1111, rdy, dout, lat);
      check($sformatf("vec%0d_data", v), 32'(dout), 32'(vecs[v].exp_data));
      check($sformatf("vec%0d_trk_ready", v), 32'(rdy), 32'(vecs[v].exp_rdy));
      check($sformatf("vec%0d_latency", v), 32'(lat), 32'd5);
    end

    // Muted track 2 not valid: frame proceeds without stalling
    program_mix(8'h80, 4'b0100);
    stall_before = stall_cnt;
    run_frame({16'h012C, 16'hDEAD, 16'h00C8, 16'h0064}, 4'b1011, rdy, dout, lat);
    check("mute_trk_ready", 32'(rdy), 32'h0000000B);
    check("mute_data", 32'(dout), 32'd300);
    check("mute_stall_cnt", 32'(stall_cnt), 32'(stall_before));

    // Missing active track: GATHER stalls and counts
    program_mix(8'h80, 4'b0000);
    stall_before = stall_cnt;
    trk_valid = 4'b0111;
    execute   = 1'b1;
    repeat (5) @(posedge axis_aclk);
    @(negedge axis_aclk);
    check("stall_cnt_delta", 32'(stall_cnt - stall_before), 32'd4);
    check("stall_no_pop", 32'(trk_ready), 32'd0);
    execute   = 1'b0;
    trk_valid = 4'b0000;
    repeat (3) @(negedge axis_aclk);

    // DAC back-pressure while the FIFO is overfilled
    program_mix(8'h40, 4'b0000);
    trk_data  = {4{16'h03E8}};
    trk_valid = 4'b1111;
    dac_ready = 1'b0;
    execute   = 1'b1;
    got_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge axis_aclk);
      if (trk_ready != 4'b0000) begin
        execute   = 1'b0;
        trk_valid = 4'b0000;
      end
      if (dac_valid) begin
        got_valid = 1'b1;
        break;
      end
    end
    execute   = 1'b0;
    trk_valid = 4'b0000;
    check("bp_dac_valid_seen", 32'(got_valid), 32'd1);
    check("bp_dac_data", 32'(dac_data), 32'h03E8);
    held      = dac_data;
    stable    = 1'b1;
    popped    = 1'b0;
    first_low = -1;
    for (int k = 0; k < 20; k++) begin
      if (dac_valid !== 1'b1 || dac_data !== held) stable = 1'b0;
      if (trk_ready !== 4'b0000) popped = 1'b1;
      if (!prog_ready && first_low < 0) first_low = k;
      if (k < 17) begin
        prog_valid = 1'b1;
        prog_data  = words[k];
      end else begin
        prog_valid = 1'b0;
      end
      @(negedge axis_aclk);
    end
    prog_valid = 1'b0;
    check("bp_output_stable", 32'(stable), 32'd1);
    check("bp_no_trk_ready", 32'(popped), 32'd0);
    check("fifo_ready_low_after", 32'(first_low), 32'd16);
    check("fifo_overflow", 32'(prog_overflow), 32'd1);
    check("fifo_full_ready", 32'(prog_ready), 32'd0);

    // Accept, then 16 pops one per cycle before the next frame can gather
    dac_ready = 1'b1;
    execute   = 1'b1;
    trk_data  = {16'h0064, 16'hFE0C, 16'h07D0, 16'h03E8};
    trk_valid = 4'b1111;
    cnt = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge axis_aclk);
      if (trk_ready != 4'b0000) begin
        cnt = i;
        break;
      end
    end
    execute   = 1'b0;
    trk_valid = 4'b0000;
    check("drain_cycles_to_pop", 32'(cnt), 32'd19);
    dout = 16'h0000;
    for (int i = 0; i < 30; i++) begin
      @(negedge axis_aclk);
      if (dac_valid) begin
        dout = dac_data;
        break;
      end
    end
    check("drain_data", 32'(dout), 32'h0514);
    @(negedge axis_aclk);

    // Reset in the middle of MAC with the DAC not ready
    program_mix(8'h80, 4'b0000);
    trk_data  = {4{16'h03E8}};
    trk_valid = 4'b1111;
    dac_ready = 1'b0;
    execute   = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge axis_aclk);
      if (trk_ready != 4'b0000) break;
    end
    @(negedge axis_aclk);
    axis_aresetn = 1'b1;
    #1;
    check("midrst_dac_valid", 32'(dac_valid), 32'd0);
    check("midrst_dac_data", 32'(dac_data), 32'd0);
    check("midrst_trk_ready", 32'(trk_ready), 32'd0);
    check("midrst_prog_ready", 32'(prog_ready), 32'd1);
    check("midrst_overflow", 32'(prog_overflow), 32'd0);
    check("midrst_stall_cnt", 32'(stall_cnt), 32'd0);
    execute   = 1'b0;
    trk_valid = 4'b0000;
    @(negedge axis_aclk);
    axis_aresetn = 1'b0;
    got_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge axis_aclk);
      if (dac_valid || trk_ready != 4'b0000) got_valid = 1'b1;
    end
    check("midrst_no_output", 32'(got_valid), 32'd0);

    // Volumes were cleared by reset
    run_frame({4{16'h03E8}}, 4'b1111, rdy, dout, lat);
    check("postrst_zero_vol", 32'(dout), 32'd0);
    check("postrst_latency", 32'(lat), 32'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
